video_mode_ctrl: RTL and testbench

VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

---
 rtl/video_mode_pkg.sv | 41 ++++
 rtl/sync_edge_det.sv | 26 ++
 rtl/video_mode_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_mode_pkg.sv
// Shared types and helpers for the video mode controller.
package video_mode_pkg;

  // Detected or committed video standard; encoding matches the o_mode port.
  typedef enum logic [1:0] {
    MODE_NONE   = 2'b00,
    MODE_PAL50  = 2'b01,
    MODE_NTSC60 = 2'b10,
    MODE_VGA    = 2'b11
  } mode_t;

  // Mode controller FSM states.
  typedef enum logic [2:0] {
    ST_SEARCH  = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_SWITCH  = 3'd2,
    ST_ALIGN   = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  localparam int LINE_W = 11;
  localparam logic [LINE_W-1:0] LINE_MAX = 11'd2047;

  // Classify one finished frame from its line count and the measured rate.
  function automatic mode_t classify(input logic [LINE_W-1:0] lines,
                                     input logic [7:0]        fps,
                                     input logic              fps_valid,
                                     input int                line_thresh,
                                     input int                fps_thresh);
    mode_t m;
    if ({21'd0, lines} > line_thresh) begin
      m = MODE_VGA;
    end else if (fps_valid) begin
      m = ({24'd0, fps} < fps_thresh) ? MODE_PAL50 : MODE_NTSC60;
    end else begin
      m = MODE_NONE;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Rising-edge detector for a signal already synchronous to clk.
// The pulse is registered, so it appears the cycle after the input rises.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  // Delay the input by one cycle and register the rising-edge pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_rise <= i_sig & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/video_mode_ctrl.sv
// Video mode controller: classifies incoming frames (PAL50 / NTSC60 / VGA),
// debounces mode changes over several frames, pulses a generator reset on a
// commit and re-aligns the generators to the next vsync before locking.
//
// i_fps/i_fps_valid form a valid-only interface: i_fps is used at a vsync
// edge only when i_fps_valid is high in that cycle; there is no ready/backpressure.
module video_mode_ctrl
  import video_mode_pkg::*;
#(
  parameter int LINE_THRESH   = 400,
  parameter int FPS_THRESH    = 58,
  parameter int STABLE_FRAMES = 4,
  parameter int RST_CYCLES    = 16,
  parameter int VS_TIMEOUT    = 4_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [7:0] i_fps,
  input  logic       i_fps_valid,
  output logic [1:0] o_mode,
  output logic       o_sel_60hz,
  output logic       o_passthrough,
  output logic       o_gen_reset,
  output logic       o_blank,
  output logic       o_locked,
  output logic       o_mode_change,
  output logic [2:0] o_dbg_state
);

  localparam int CNT_W = $clog2(STABLE_FRAMES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W  = $clog2(VS_TIMEOUT + 1);

  logic              w_hs_rise;
  logic              w_vs_rise;
  logic              w_timeout;
  logic              w_frame_done;
  mode_t             w_class;

  logic [LINE_W-1:0] r_line_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_frame_started;

  state_t            r_state;
  mode_t             r_mode;
  mode_t             r_cand;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_mis_cnt;
  logic [RST_W-1:0]  r_rst_cnt;
  logic              r_gen_reset;
  logic              r_mode_change;
  logic              r_sel_60hz;
  logic              r_passthrough;
  logic              r_locked;
  logic              r_blank;

  sync_edge_det u_hs_edge (
    .clk   (clk),
    .reset (reset),
    .i_sig (i_hsync),
    .o_rise(w_hs_rise)
  );

  sync_edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .i_sig (i_vsync),
    .o_rise(w_vs_rise)
  );

  assign w_timeout    = (r_to_cnt == TO_W'(VS_TIMEOUT));
  // The first vsync after reset or signal loss only opens a frame; it is not classified.
  assign w_frame_done = w_vs_rise & r_frame_started;
  assign w_class      = classify(r_line_cnt, i_fps, i_fps_valid, LINE_THRESH, FPS_THRESH);

  // Line counter, vsync timeout counter and frame-open flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line_cnt      <= '0;
      r_to_cnt        <= '0;
      r_frame_started <= 1'b0;
    end else begin
      if (w_vs_rise) begin
        // A coincident hsync is line 1 of the new frame.
        r_line_cnt      <= w_hs_rise ? 11'd1 : 11'd0;
        r_to_cnt        <= '0;
        r_frame_started <= 1'b1;
      end else begin
        if (w_hs_rise && (r_line_cnt != LINE_MAX)) begin
          r_line_cnt <= r_line_cnt + 11'd1;
        end
        if (!w_timeout) begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end else begin
          r_frame_started <= 1'b0;
        end
      end
    end
  end

  // Mode FSM: search, confirm, generator reset, frame align and lock supervision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_SEARCH;
      r_mode        <= MODE_NONE;
      r_cand        <= MODE_NONE;
      r_cnt         <= '0;
      r_mis_cnt     <= '0;
      r_rst_cnt     <= '0;
      r_gen_reset   <= 1'b0;
      r_mode_change <= 1'b0;
    end else begin
      r_mode_change <= 1'b0;
      if (w_timeout && (r_state != ST_SEARCH)) begin
        r_state     <= ST_SEARCH;
        r_mode      <= MODE_NONE;
        r_gen_reset <= 1'b0;
        r_cnt       <= '0;
        r_mis_cnt   <= '0;
        r_rst_cnt   <= '0;
      end else begin
        case (r_state)
          ST_SEARCH: begin
            if (w_frame_done && (w_class != MODE_NONE)) begin
              r_cand  <= w_class;
              r_cnt   <= CNT_W'(1);
              r_state <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (w_frame_done) begin
              if (w_class == r_cand) begin
                if (r_cnt >= CNT_W'(STABLE_FRAMES - 1)) begin
                  r_mode        <= r_cand;
                  r_mode_change <= 1'b1;
                  r_gen_reset   <= 1'b1;
                  r_rst_cnt     <= '0;
                  r_cnt         <= '0;
                  r_state       <= ST_SWITCH;
                end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
                end
              end else if (w_class == MODE_NONE) begin
                r_cnt   <= '0;
                r_state <= ST_SEARCH;
              end else begin
                r_cand <= w_class;
                r_cnt  <= CNT_W'(1);
              end
            end
          end
          ST_SWITCH: begin
            if (r_rst_cnt == RST_W'(RST_CYCLES - 1)) begin
              r_gen_reset <= 1'b0;
              r_rst_cnt   <= '0;
              r_state     <= ST_ALIGN;
            end else begin
              r_rst_cnt <= r_rst_cnt + RST_W'(1);
            end
          end
          ST_ALIGN: begin
            // Release into LOCKED on a frame boundary so generators start aligned.
            if (w_vs_rise) begin
              r_mis_cnt <= '0;
              r_state   <= ST_LOCKED;
            end
          end
          ST_LOCKED: begin
            if (w_frame_done) begin
              if (w_class == r_mode) begin
                r_mis_cnt <= '0;
              end else if (r_mis_cnt >= CNT_W'(STABLE_FRAMES - 1)) begin
                r_mis_cnt <= '0;
                r_mode    <= MODE_NONE;
                r_state   <= ST_SEARCH;
              end else begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
              end
            end
          end
          default: begin
            r_state <= ST_SEARCH;
          end
        endcase
      end
    end
  end

  // Registered output decode of the committed mode and lock state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_60hz    <= 1'b0;
      r_passthrough <= 1'b0;
      r_locked      <= 1'b0;
      r_blank       <= 1'b1;
    end else begin
      r_sel_60hz    <= (r_mode == MODE_NTSC60);
      r_passthrough <= (r_mode == MODE_VGA);
      r_locked      <= (r_state == ST_LOCKED);
      r_blank       <= (r_state != ST_LOCKED);
    end
  end

  assign o_mode        = r_mode;
  assign o_sel_60hz    = r_sel_60hz;
  assign o_passthrough = r_passthrough;
  assign o_gen_reset   = r_gen_reset;
  assign o_blank       = r_blank;
  assign o_locked      = r_locked;
  assign o_mode_change = r_mode_change;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Directed bench for video_mode_ctrl: frames are driven line by line and
// every expected mode commit is queued, then matched on o_mode_change.
module tb_video_mode_ctrl;

  localparam int TB_TIMEOUT = 3000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_hsync = 1'b0;
  logic       i_vsync = 1'b0;
  logic [7:0] i_fps = 8'd0;
  logic       i_fps_valid = 1'b0;
  logic [1:0] o_mode;
  logic       o_sel_60hz;
  logic       o_passthrough;
  logic       o_gen_reset;
  logic       o_blank;
  logic       o_locked;
  logic       o_mode_change;
  logic [2:0] o_dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int gr_len = 0;
  logic [1:0] exp_q[$];

  video_mode_ctrl #(
    .LINE_THRESH  (400),
    .FPS_THRESH   (58),
    .STABLE_FRAMES(4),
    .RST_CYCLES   (16),
    .VS_TIMEOUT   (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .i_fps        (i_fps),
    .i_fps_valid  (i_fps_valid),
    .o_mode       (o_mode),
    .o_sel_60hz   (o_sel_60hz),
    .o_passthrough(o_passthrough),
    .o_gen_reset  (o_gen_reset),
    .o_blank      (o_blank),
    .o_locked     (o_locked),
    .o_mode_change(o_mode_change),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: lines are 2 clk long, vsync is a 1-clk pulse.
  task automatic drive_line();
    @(negedge clk) i_hsync = 1'b1;
    @(negedge clk) i_hsync = 1'b0;
  endtask

  task automatic drive_vsync(input logic coinc);
    @(negedge clk) begin
      i_vsync = 1'b1;
      i_hsync = coinc;
    end
    @(negedge clk) begin
      i_vsync = 1'b0;
      i_hsync = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_frame(input int lines, input logic [7:0] fps, input logic fv, input logic coinc);
    i_fps = fps;
    i_fps_valid = fv;
    repeat (lines) drive_line();
    drive_vsync(coinc);
  endtask

  // Scoreboard: each commit pulse pops the expected mode; also measures gen_reset width.
  always @(negedge clk) begin
    if (!reset) begin
      gr_len = 0;
    end else begin
      if (o_mode_change) begin
        check("commit_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("commit_mode", {30'd0, o_mode}, {30'd0, exp_q.pop_front()});
      end
      if (o_gen_reset) begin
        gr_len++;
      end else if (gr_len != 0) begin
        check("gen_reset_len", gr_len, 32'd16);
        gr_len = 0;
      end
    end
  end

  initial begin
    // Reset values, checked while reset is held.
    #12;
    check("rst_mode", {30'd0, o_mode}, 32'd0);
    check("rst_blank", {31'd0, o_blank}, 32'd1);
    check("rst_locked", {31'd0, o_locked}, 32'd0);
    check("rst_gen_reset", {31'd0, o_gen_reset}, 32'd0);
    check("rst_mode_change", {31'd0, o_mode_change}, 32'd0);
    check("rst_sel60", {31'd0, o_sel_60hz}, 32'd0);
    check("rst_pass", {31'd0, o_passthrough}, 32'd0);
    check("rst_state", {29'd0, o_dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // PAL50 acquisition; the leading partial frame must not be counted.
    drive_frame(312, 8'd50, 1'b1, 1'b0);
    repeat (3) drive_frame(312, 8'd50, 1'b1, 1'b0);
    check("pal_no_early_commit", {30'd0, o_mode}, 32'd0);
    exp_q.push_back(2'b01);
    drive_frame(312, 8'd50, 1'b1, 1'b0);
    check("pal_mode", {30'd0, o_mode}, 32'd1);
    check("pal_gen_reset_on", {31'd0, o_gen_reset}, 32'd1);
    check("pal_not_locked_yet", {31'd0, o_locked}, 32'd0);
    drive_frame(312, 8'd50, 1'b1, 1'b0);
    check("pal_locked", {31'd0, o_locked}, 32'd1);
    check("pal_unblank", {31'd0, o_blank}, 32'd0);
    check("pal_gen_reset_off", {31'd0, o_gen_reset}, 32'd0);
    check("pal_state", {29'd0, o_dbg_state}, 32'd4);

    // PAL50 -> NTSC60: three mismatches keep lock, the fourth drops it.
    repeat (3) drive_frame(262, 8'd60, 1'b1, 1'b0);
    check("mis3_still_locked", {31'd0, o_locked}, 32'd1);
    drive_frame(262, 8'd60, 1'b1, 1'b0);
    check("loss_blank", {31'd0, o_blank}, 32'd1);
    check("loss_mode", {30'd0, o_mode}, 32'd0);
    repeat (3) drive_frame(262, 8'd60, 1'b1, 1'b0);
    check("ntsc_hold_none", {30'd0, o_mode}, 32'd0);
    exp_q.push_back(2'b10);
    drive_frame(262, 8'd60, 1'b1, 1'b0);
    check("ntsc_mode", {30'd0, o_mode}, 32'd2);
    check("ntsc_sel60", {31'd0, o_sel_60hz}, 32'd1);
    drive_frame(262, 8'd60, 1'b1, 1'b0);
    check("ntsc_locked", {31'd0, o_locked}, 32'd1);

    // VGA by line count, regardless of fps validity.
    for (int f = 0; f < 4; f++) drive_frame(525, 8'd50, f[0], 1'b0);
    check("vga_loss_mode", {30'd0, o_mode}, 32'd0);
    for (int f = 0; f < 3; f++) drive_frame(525, 8'd60, f[0], 1'b0);
    exp_q.push_back(2'b11);
    drive_frame(525, 8'd50, 1'b0, 1'b0);
    check("vga_mode", {30'd0, o_mode}, 32'd3);
    check("vga_pass", {31'd0, o_passthrough}, 32'd1);
    check("vga_sel60", {31'd0, o_sel_60hz}, 32'd0);
    drive_frame(525, 8'd50, 1'b0, 1'b0);
    check("vga_locked", {31'd0, o_locked}, 32'd1);

    // Vsync loss: still locked before the timeout, searching after it.
    repeat (2500) @(negedge clk);
    check("pre_timeout_locked", {31'd0, o_locked}, 32'd1);
    repeat (700) @(negedge clk);
    check("timeout_mode", {30'd0, o_mode}, 32'd0);
    check("timeout_blank", {31'd0, o_blank}, 32'd1);
    check("timeout_gen_reset", {31'd0, o_gen_reset}, 32'd0);
    drive_vsync(1'b0);
    repeat (3) drive_frame(312, 8'd50, 1'b1, 1'b0);
    exp_q.push_back(2'b01);
    drive_frame(312, 8'd50, 1'b1, 1'b0);
    check("relock_mode", {30'd0, o_mode}, 32'd1);
    drive_frame(312, 8'd50, 1'b1, 1'b0);
    check("relock_locked", {31'd0, o_locked}, 32'd1);

    // CONFIRM restart: 50, 57 (PAL) then 58, 60, 58, 60 (NTSC).
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_vsync(1'b0);
    drive_frame(400, 8'd50, 1'b1, 1'b0);
    drive_frame(400, 8'd57, 1'b1, 1'b0);
    drive_frame(262, 8'd58, 1'b1, 1'b0);
    drive_frame(262, 8'd60, 1'b1, 1'b0);
    drive_frame(262, 8'd58, 1'b1, 1'b0);
    check("confirm5_no_commit", {30'd0, o_mode}, 32'd0);
    exp_q.push_back(2'b10);
    drive_frame(262, 8'd60, 1'b1, 1'b0);
    check("confirm6_ntsc", {30'd0, o_mode}, 32'd2);
    drive_frame(262, 8'd60, 1'b1, 1'b0);
    // Exactly LINE_THRESH lines is not VGA, so lock must hold.
    repeat (4) drive_frame(400, 8'd60, 1'b1, 1'b0);
    check("thresh400_locked", {31'd0, o_locked}, 32'd1);
    check("thresh400_mode", {30'd0, o_mode}, 32'd2);

    // Reset during SWITCH clears outputs immediately.
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_vsync(1'b0);
    repeat (3) drive_frame(312, 8'd50, 1'b1, 1'b0);
    exp_q.push_back(2'b01);
    drive_frame(312, 8'd50, 1'b1, 1'b0);
    check("switch_gen_reset", {31'd0, o_gen_reset}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_gen_reset", {31'd0, o_gen_reset}, 32'd0);
    check("async_mode", {30'd0, o_mode}, 32'd0);
    check("async_blank", {31'd0, o_blank}, 32'd1);
    check("async_state", {29'd0, o_dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Coincident hsync+vsync: that hsync is line 1, so 400 more lines gives 401 -> VGA.
    drive_vsync(1'b1);
    repeat (3) drive_frame(400, 8'd50, 1'b1, 1'b1);
    exp_q.push_back(2'b11);
    drive_frame(400, 8'd50, 1'b1, 1'b1);
    check("coinc_vga_mode", {30'd0, o_mode}, 32'd3);
    check("coinc_vga_pass", {31'd0, o_passthrough}, 32'd1);

    repeat (20) @(negedge clk);
    check("commits_all_seen", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
